packet_ram_unaligned: RTL

//  Byte-addressed packet buffer for the BPF datapath: 32-bit-granular word writes with byte enables,
//  and pipelined single-cycle-throughput unaligned reads of 1, 2 or 4 bytes at any byte address.

---
 rtl/packet_ram_unaligned.sv | 122 ++++++++++++
 1 files changed

// File: rtl/packet_ram_unaligned.sv
// Byte-addressed packet buffer: byte-enabled word writes, pipelined
// big-endian unaligned 1/2/4-byte reads fetched as a word pair.
module packet_ram_unaligned #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    localparam int NB        = DATA_WIDTH / 8,
    localparam int BYTE_BITS = $clog2(NB)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic [NB-1:0]                   wr_be,
    input  logic                            rd_en,
    output logic                            rd_ready,
    input  logic [ADDR_WIDTH+BYTE_BITS-1:0] rd_addr,
    input  logic [1:0]                      rd_sz,
    output logic [31:0]                     rd_data,
    output logic                            rd_valid,
    output logic                            rd_err
);

    localparam int PW = $clog2(2 * DATA_WIDTH);

    logic [DATA_WIDTH-1:0]   r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   r_qa;
    logic [DATA_WIDTH-1:0]   r_qb;
    logic                    r_v1;
    logic [BYTE_BITS-1:0]    r_off1;
    logic [1:0]              r_sz1;
    logic [31:0]             r_data;
    logic                    r_valid;
    logic                    r_err;

    logic                    w_acc;
    logic                    w_ce;
    logic [ADDR_WIDTH-1:0]   w_rd_word;
    logic [ADDR_WIDTH-1:0]   w_rd_next;
    logic [ADDR_WIDTH-1:0]   w_addr_a;
    logic [2*DATA_WIDTH-1:0] w_pair;
    logic [PW-1:0]           w_base;
    logic [31:0]             w_top;
    logic [31:0]             w_ext;
    logic                    w_err;

    assign rd_ready  = ~wr_en;
    assign w_acc     = rd_en & rd_ready;
    assign w_ce      = wr_en | w_acc;
    assign w_rd_word = rd_addr[ADDR_WIDTH+BYTE_BITS-1:BYTE_BITS];
    assign w_rd_next = w_rd_word + ADDR_WIDTH'(1);
    assign w_addr_a  = wr_en ? wr_addr : w_rd_word;

    // Port A: shared write/read address, read-first
    always_ff @(posedge clk) begin
        if (w_ce) begin
            r_qa <= r_mem[w_addr_a];
        end
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) begin
                    r_mem[wr_addr][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
        end
    end

    // Port B: following word, wraps to word 0
    always_ff @(posedge clk) begin
        if (w_ce) begin
            r_qb <= r_mem[w_rd_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_off1 <= '0;
            r_sz1  <= '0;
        end else begin
            r_v1 <= w_acc;
            if (w_acc) begin
                r_off1 <= rd_addr[BYTE_BITS-1:0];
                r_sz1  <= rd_sz;
            end
        end
    end

    assign w_pair = {r_qa, r_qb};
    assign w_base = PW'(2*DATA_WIDTH-1) - PW'({r_off1, 3'b000});
    assign w_top  = w_pair[w_base -: 32];

    always_comb begin
        w_ext = '0;
        w_err = 1'b0;
        unique case (r_sz1)
            2'b00:   w_ext = {24'd0, w_top[31:24]};
            2'b01:   w_ext = {16'd0, w_top[31:16]};
            2'b10:   w_ext = w_top;
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= r_v1;
            r_err   <= r_v1 & w_err;
            if (r_v1) begin
                r_data <= w_ext;
            end
        end
    end

    assign rd_data  = r_data;
    assign rd_valid = r_valid;
    assign rd_err   = r_err;

endmodule
